seg_scroll_source: RTL and testbench

SEG_SCROLL_SOURCE -- requirements
Module: seg_scroll_source

---
 rtl/seg_scroll_source.sv | 174 +++++++++++++++++
 tb/tb_seg_scroll_source.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scroll_source.sv
// ---------------------------------------------------------------------------
// seg_scroll_source
//
// Purpose:
//   Scrolls a short message across three 7-segment digits. A 16-entry
//   message store holds raw segment patterns. On start, the block shows the
//   entries at positions pos, pos+1 and pos+2 (modulo the message length).
//   It advances pos by one every N_TICK clock cycles until stop is seen.
//
// Ports:
//   clk      - system clock; all state changes happen on its rising edge
//   rst_n    - asynchronous active-low reset
//   wr_en    - write strobe for the message store (accepted in any state)
//   wr_addr  - message store write address
//   wr_char  - segment pattern {dp,g,f,e,d,c,b,a}, active-high
//   len      - message length 1..16, sampled only when start is accepted
//   start    - single-cycle pulse; (re)starts scrolling from position 0
//   stop     - single-cycle pulse; halts scrolling and blanks the digits
//   digit_l  - leftmost digit pattern   (shows entry pos)
//   digit_m  - middle digit pattern     (shows entry pos+1)
//   digit_r  - rightmost digit pattern  (shows entry pos+2)
//   running  - high while scrolling
//   step     - one-cycle pulse on each scroll advance
// ---------------------------------------------------------------------------
module seg_scroll_source #(
    parameter int unsigned N_TICK = 50000000,
    parameter int unsigned DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_char,
    input  logic [4:0] len,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] digit_l,
    output logic [7:0] digit_m,
    output logic [7:0] digit_r,
    output logic       running,
    output logic       step
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [31:0] TICK_LAST = 32'(N_TICK - 1);

    state_t      state_q, state_d;
    logic [3:0]  pos_q, pos_d;
    logic [31:0] cnt_q, cnt_d;
    logic [4:0]  len_q, len_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic [7:0]  digit_l_q, digit_l_d;
    logic [7:0]  digit_m_q, digit_m_d;
    logic [7:0]  digit_r_q, digit_r_d;
    logic        running_q, running_d;
    logic        step_q, step_d;

    logic        len_ok;
    logic [4:0]  p1_w;
    logic [4:0]  p2_w;

    // Message store: a write lands at the edge regardless of FSM state.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[wr_addr] = wr_char;
        end
    end

    // Positions of the middle and right digits, modulo len_q.
    // pos_q < len_q always holds, so pos+1 needs at most one wrap. pos+2 can
    // need two wraps when len_q is 1 (2 -> 1 -> 0).
    always_comb begin
        p1_w = {1'b0, pos_q} + 5'd1;
        if (p1_w >= len_q) begin
            p1_w = p1_w - len_q;
        end
        p2_w = {1'b0, pos_q} + 5'd2;
        if (p2_w >= len_q) begin
            p2_w = p2_w - len_q;
        end
        if (p2_w >= len_q) begin
            p2_w = p2_w - len_q;
        end
    end

    assign len_ok = (len != 5'd0) && (len <= 5'd16);

    // Next-state logic. Priority is stop, then an accepted start (restart),
    // then the tick counter. A start with an out-of-range len is ignored.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        step_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            pos_d   = 4'd0;
            cnt_d   = 32'd0;
        end else if (start && len_ok) begin
            state_d = RUN;
            len_d   = len;
            pos_d   = 4'd0;
            cnt_d   = 32'd0;
        end else if (state_q == RUN) begin
            if (cnt_q == TICK_LAST) begin
                cnt_d  = 32'd0;
                pos_d  = p1_w[3:0];
                step_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
        running_d = (state_d == RUN);
    end

    // Digit outputs follow the current position and store contents with one
    // cycle of latency. They are blanked while idle.
    always_comb begin
        digit_l_d = 8'h00;
        digit_m_d = 8'h00;
        digit_r_d = 8'h00;
        if (state_q == RUN) begin
            digit_l_d = mem_q[pos_q];
            digit_m_d = mem_q[p1_w[3:0]];
            digit_r_d = mem_q[p2_w[3:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pos_q     <= 4'd0;
            cnt_q     <= 32'd0;
            len_q     <= 5'd1;
            digit_l_q <= 8'h00;
            digit_m_q <= 8'h00;
            digit_r_q <= 8'h00;
            running_q <= 1'b0;
            step_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            digit_l_q <= digit_l_d;
            digit_m_q <= digit_m_d;
            digit_r_q <= digit_r_d;
            running_q <= running_d;
            step_q    <= step_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign digit_l = digit_l_q;
    assign digit_m = digit_m_q;
    assign digit_r = digit_r_q;
    assign running = running_q;
    assign step    = step_q;

endmodule

// File: tb/tb_seg_scroll_source.sv
// ---------------------------------------------------------------------------
// tb_seg_scroll_source
//
// Self-checking bench for seg_scroll_source with N_TICK=4. A behavioural
// model tracks the store, the run flag, the position and the tick count with
// plain integer arithmetic. Outputs are compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_seg_scroll_source;

    localparam int NT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [7:0] wr_char = 8'h00;
    logic [4:0] len = 5'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] digit_l, digit_m, digit_r;
    logic       running, step;

    int checks = 0;
    int failures = 0;
    int stepSeen = 0;

    // Behavioural model state
    logic [7:0] mMem [16];
    bit         mRun;
    int         mPos, mCnt, mLen;
    logic [7:0] mDl, mDm, mDr;
    bit         mStep;

    seg_scroll_source #(.N_TICK(NT), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .len(len), .start(start), .stop(stop),
        .digit_l(digit_l), .digit_m(digit_m), .digit_r(digit_r),
        .running(running), .step(step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mMem[i] = 8'h00;
        mRun = 0; mPos = 0; mCnt = 0; mLen = 1;
        mDl = 8'h00; mDm = 8'h00; mDr = 8'h00; mStep = 0;
    endtask

    // Advance the model by one rising edge using the inputs present at it.
    task automatic modelEdge();
        logic [7:0] nl, nm, nr;
        int lv;
        nl = 8'h00; nm = 8'h00; nr = 8'h00;
        if (mRun) begin
            nl = mMem[mPos];
            nm = mMem[(mPos + 1) % mLen];
            nr = mMem[(mPos + 2) % mLen];
        end
        lv = int'(len);
        mStep = 0;
        if (stop) begin
            mRun = 0; mPos = 0; mCnt = 0;
        end else if (start && lv >= 1 && lv <= 16) begin
            mRun = 1; mLen = lv; mPos = 0; mCnt = 0;
        end else if (mRun) begin
            if (mCnt == NT - 1) begin
                mCnt = 0;
                mPos = (mPos + 1) % mLen;
                mStep = 1;
            end else begin
                mCnt = mCnt + 1;
            end
        end
        if (wr_en) mMem[wr_addr] = wr_char;
        mDl = nl; mDm = nm; mDr = nr;
    endtask

    task automatic checkOutput();
        chk("digit_l", 32'(digit_l), 32'(mDl));
        chk("digit_m", 32'(digit_m), 32'(mDm));
        chk("digit_r", 32'(digit_r), 32'(mDr));
        chk("running", 32'(running), 32'(mRun));
        chk("step",    32'(step),    32'(mStep));
        if (step === 1'b1) stepSeen++;
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [7:0] wc,
                                 input logic [4:0] ln, input logic st, input logic sp);
        wr_en = we; wr_addr = wa; wr_char = wc; len = ln; start = st; stop = sp;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0; stop = 1'b0;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 8'h00, len, 1'b0, 1'b0);
    endtask

    task automatic checkDigits(input string tag, input logic [7:0] l, input logic [7:0] m,
                               input logic [7:0] r, input logic run);
        chk({tag, "_l"}, 32'(digit_l), 32'(l));
        chk({tag, "_m"}, 32'(digit_m), 32'(m));
        chk({tag, "_r"}, 32'(digit_r), 32'(r));
        chk({tag, "_run"}, 32'(running), 32'(run));
    endtask

    initial begin
        modelReset();
        #3;
        checkDigits("reset", 8'h00, 8'h00, 8'h00, 1'b0);
        chk("reset_step", 32'(step), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load "S", "E", "P" patterns and scroll them.
        applyStimulus(1'b1, 4'd0, 8'h6D, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd1, 8'h79, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd2, 8'h73, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 8'h00, 5'd3, 1'b1, 1'b0);
        stepSeen = 0;
        idle(2);
        checkDigits("len3_first", 8'h6D, 8'h79, 8'h73, 1'b1);
        idle(3);
        checkDigits("len3_pos1", 8'h79, 8'h73, 8'h6D, 1'b1);
        idle(4);
        checkDigits("len3_pos2", 8'h73, 8'h6D, 8'h79, 1'b1);
        idle(4);
        checkDigits("len3_wrap", 8'h6D, 8'h79, 8'h73, 1'b1);
        chk("len3_steps", 32'(stepSeen), 32'd3);

        // Stop, then starts with illegal lengths are ignored.
        applyStimulus(1'b0, 4'd0, 8'h00, 5'd3, 1'b0, 1'b1);
        applyStimulus(1'b0, 4'd0, 8'h00, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 8'h00, 5'd17, 1'b1, 1'b0);
        idle(2);
        checkDigits("illegal_len", 8'h00, 8'h00, 8'h00, 1'b0);

        // Single-entry message: all digits identical, steps still pulse.
        applyStimulus(1'b1, 4'd0, 8'h3F, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 8'h00, 5'd1, 1'b1, 1'b0);
        stepSeen = 0;
        idle(2);
        checkDigits("len1", 8'h3F, 8'h3F, 8'h3F, 1'b1);
        idle(8);
        checkDigits("len1_late", 8'h3F, 8'h3F, 8'h3F, 1'b1);
        chk("len1_steps", 32'(stepSeen), 32'd2);

        // Start and stop together: stop wins.
        applyStimulus(1'b0, 4'd0, 8'h00, 5'd3, 1'b1, 1'b1);
        chk("startstop_run", 32'(running), 32'd0);
        idle(1);
        checkDigits("startstop", 8'h00, 8'h00, 8'h00, 1'b0);

        // Async reset mid-run at pos=1.
        applyStimulus(1'b0, 4'd0, 8'h00, 5'd3, 1'b1, 1'b0);
        idle(5);
        checkDigits("pre_reset", 8'h79, 8'h73, 8'h3F, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        checkDigits("async_reset", 8'h00, 8'h00, 8'h00, 1'b0);
        chk("async_reset_step", 32'(step), 32'd0);
        modelReset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput();
        stepSeen = 0;
        idle(6);
        chk("post_reset_steps", 32'(stepSeen), 32'd0);
        applyStimulus(1'b0, 4'd0, 8'h00, 5'd3, 1'b1, 1'b0);
        idle(2);
        checkDigits("store_cleared", 8'h00, 8'h00, 8'h00, 1'b1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          8'($urandom), 5'($urandom_range(0, 20)),
                          1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 29) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
